// File: rtl/wb_skid_stage_if.sv
// Writeback bundle bus between the issue side, the skid stage and the regfile.
// The upstream channel (in_*), the downstream channel (out_*) and the
// forwarding lookup (fwd_*) travel together so the stage can be dropped
// between producer and regfile as a single connection.
interface wb_skid_stage_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*ADDR_W-1:0]   in_addr;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [LANES-1:0]          in_we;

    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*ADDR_W-1:0]   out_addr;
    logic [LANES*DATA_W-1:0]   out_data;
    logic [LANES-1:0]          out_we;

    logic [ADDR_W-1:0]         fwd_addr;
    logic                      fwd_hit;
    logic [DATA_W-1:0]         fwd_data;

    // Stage side: consumes bundles and forwarding queries.
    modport slave (
        input  in_valid, in_addr, in_data, in_we, out_ready, fwd_addr,
        output in_ready, out_valid, out_addr, out_data, out_we, fwd_hit, fwd_data
    );

    // Environment side: produces bundles, drains the head, issues lookups.
    modport master (
        output in_valid, in_addr, in_data, in_we, out_ready, fwd_addr,
        input  in_ready, out_valid, out_addr, out_data, out_we, fwd_hit, fwd_data
    );
endinterface

// File: rtl/wb_skid_stage.sv
// Two-entry in-order writeback skid buffer with register forwarding.
// E0 is the head presented to the regfile, E1 is the skid slot that absorbs
// one extra bundle so in_ready never depends combinationally on out_ready.
// Writes to x0 are neutralised at capture; the forwarding lookup scans all
// buffered lanes with the youngest match winning.
module wb_skid_stage #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    wb_skid_stage_if.slave     bus,
    output logic [1:0]         occ
);

    logic [LANES*ADDR_W-1:0] e0_addr, e1_addr;
    logic [LANES*DATA_W-1:0] e0_data, e1_data;
    logic [LANES-1:0]        e0_we,   e1_we;

    logic                    push;
    logic                    pop;
    logic [LANES-1:0]        cap_we;
    logic                    fwd_hit_c;
    logic [DATA_W-1:0]       fwd_data_c;

    // Clear the write enable of any lane targeting x0; addr and data are kept.
    function automatic logic [LANES-1:0] mask_x0(
        input logic [LANES*ADDR_W-1:0] addr,
        input logic [LANES-1:0]        we
    );
        logic [LANES-1:0] m;
        m = we;
        for (int i = 0; i < LANES; i++) begin
            if (addr[i*ADDR_W +: ADDR_W] == '0) m[i] = 1'b0;
        end
        return m;
    endfunction

    assign bus.in_ready  = rdy_in && (occ != 2'd2);
    assign bus.out_valid = rdy_in && (occ != 2'd0);
    assign bus.out_addr  = e0_addr;
    assign bus.out_data  = e0_data;
    assign bus.out_we    = e0_we;
    assign bus.fwd_hit   = fwd_hit_c;
    assign bus.fwd_data  = fwd_data_c;

    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;
    assign cap_we = mask_x0(bus.in_addr, bus.in_we);

    // Buffer update: freeze on !rdy_in, flush beats push/pop, pop shifts E1 into E0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            occ     <= 2'd0;
            e0_addr <= '0;
            e0_data <= '0;
            e0_we   <= '0;
            e1_addr <= '0;
            e1_data <= '0;
            e1_we   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                occ   <= 2'd0;
                e0_we <= '0;
                e1_we <= '0;
            end else if (push && pop) begin
                // in_ready is low at occ 2, so the survivor is always E0 here
                // and the incoming bundle replaces the retiring head.
                e0_addr <= bus.in_addr;
                e0_data <= bus.in_data;
                e0_we   <= cap_we;
            end else if (pop) begin
                e0_addr <= e1_addr;
                e0_data <= e1_data;
                e0_we   <= e1_we;
                occ     <= occ - 2'd1;
            end else if (push) begin
                if (occ == 2'd0) begin
                    e0_addr <= bus.in_addr;
                    e0_data <= bus.in_data;
                    e0_we   <= cap_we;
                end else begin
                    e1_addr <= bus.in_addr;
                    e1_data <= bus.in_data;
                    e1_we   <= cap_we;
                end
                occ <= occ + 2'd1;
            end
        end
    end

    // Forwarding lookup: later matches override earlier ones, so scanning
    // E0 then E1, lane 0 upward, leaves the youngest matching lane in place.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        if (bus.fwd_addr != '0) begin
            if (occ != 2'd0) begin
                for (int i = 0; i < LANES; i++) begin
                    if (e0_we[i] && (e0_addr[i*ADDR_W +: ADDR_W] == bus.fwd_addr)) begin
                        fwd_hit_c  = 1'b1;
                        fwd_data_c = e0_data[i*DATA_W +: DATA_W];
                    end
                end
            end
            if (occ == 2'd2) begin
                for (int i = 0; i < LANES; i++) begin
                    if (e1_we[i] && (e1_addr[i*ADDR_W +: ADDR_W] == bus.fwd_addr)) begin
                        fwd_hit_c  = 1'b1;
                        fwd_data_c = e1_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: directed scenarios followed by random traffic,
// all checked against a queue-based model of the writeback buffer.
module tb_wb_skid_stage;
    localparam int L = 2;
    localparam int A = 5;
    localparam int D = 32;

    typedef struct packed {
        logic [L*A-1:0] addr;
        logic [L*D-1:0] data;
        logic [L-1:0]   we;
    } bundle_t;

    logic       clk_in   = 1'b0;
    logic       rst_in   = 1'b0;
    logic       rdy_in   = 1'b0;
    logic       flush_in = 1'b0;
    logic [1:0] occ;

    wb_skid_stage_if #(.LANES(L), .DATA_W(D), .ADDR_W(A)) bus ();

    wb_skid_stage #(.LANES(L), .DATA_W(D), .ADDR_W(A)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus),
        .occ      (occ)
    );

    always #5 clk_in = ~clk_in;

    int      n_checks = 0;
    int      n_errors = 0;
    bundle_t q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [A-1:0] a0, input logic [D-1:0] d0, input logic w0,
                                   input logic [A-1:0] a1, input logic [D-1:0] d1, input logic w1);
        bundle_t b;
        b.addr = {a1, a0};
        b.data = {d1, d0};
        b.we   = {w1, w0};
        return b;
    endfunction

    function automatic bundle_t bk(input int k);
        return mk(A'(k), D'(32'h100 + k), 1'b1, A'(k + 10), D'(32'h200 + k), 1'b1);
    endfunction

    task automatic drive(input bundle_t b);
        bus.in_addr = b.addr;
        bus.in_data = b.data;
        bus.in_we   = b.we;
    endtask

    // Youngest bundle first, highest lane first: first match is the answer.
    task automatic model_fwd(output logic hit, output logic [D-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (bus.fwd_addr != 0) begin
            for (int e = q.size() - 1; e >= 0 && !hit; e--) begin
                for (int l = L - 1; l >= 0 && !hit; l--) begin
                    if (q[e].we[l] && q[e].addr[l*A +: A] == bus.fwd_addr) begin
                        hit  = 1'b1;
                        data = q[e].data[l*D +: D];
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        logic         hit;
        logic [D-1:0] fd;
        check_val("occ", 64'(occ), 64'(q.size()));
        check_val("in_ready", 64'(bus.in_ready), 64'(rdy_in && q.size() < 2));
        check_val("out_valid", 64'(bus.out_valid), 64'(rdy_in && q.size() > 0));
        if (q.size() > 0) begin
            check_val("out_addr", 64'(bus.out_addr), 64'(q[0].addr));
            check_val("out_data", 64'(bus.out_data), 64'(q[0].data));
            check_val("out_we", 64'(bus.out_we), 64'(q[0].we));
        end
        model_fwd(hit, fd);
        check_val("fwd_hit", 64'(bus.fwd_hit), 64'(hit));
        check_val("fwd_data", 64'(bus.fwd_data), 64'(fd));
    endtask

    task automatic model_edge();
        bundle_t b;
        bit      can_push;
        bit      can_pop;
        if (!rdy_in) return;
        if (flush_in) begin
            q.delete();
            return;
        end
        can_push = q.size() < 2;
        can_pop  = q.size() > 0;
        if (can_pop && bus.out_ready) void'(q.pop_front());
        if (can_push && bus.in_valid) begin
            b.addr = bus.in_addr;
            b.data = bus.in_data;
            b.we   = bus.in_we;
            for (int l = 0; l < L; l++)
                if (b.addr[l*A +: A] == 0) b.we[l] = 1'b0;
            q.push_back(b);
        end
    endtask

    task automatic cycle();
        @(negedge clk_in);
        check_model();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fwd_addr  = '0;
        drive(mk(0, 0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check_val("rst_occ", 64'(occ), 64'd0);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_out_we", 64'(bus.out_we), 64'd0);
        check_val("rst_out_addr", 64'(bus.out_addr), 64'd0);
        check_val("rst_out_data", 64'(bus.out_data), 64'd0);
        check_val("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);

        // Pass-through, pushed on the first edge after reset release
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(mk(3, 32'h11, 1, 7, 32'h22, 1));
        cycle();
        bus.in_valid = 1'b0;
        check_val("pt_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("pt_out_we", 64'(bus.out_we), 64'b11);
        check_val("pt_out_addr", 64'(bus.out_addr), 64'({5'd7, 5'd3}));
        check_val("pt_out_data", 64'(bus.out_data), {32'h22, 32'h11});
        cycle();
        check_val("pt_occ_back", 64'(occ), 64'd0);

        // Backpressure: third bundle held upstream, drained in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive(bk(k));
            cycle();
            if (k == 2) begin
                check_val("bp_occ_full", 64'(occ), 64'd2);
                check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
            end
        end
        check_val("bp_head_b1", 64'(bus.out_data), 64'(bk(1).data));
        bus.out_ready = 1'b1;
        cycle();
        check_val("bp_head_b2", 64'(bus.out_data), 64'(bk(2).data));
        cycle();
        check_val("bp_head_b3", 64'(bus.out_data), 64'(bk(3).data));
        check_val("bp_occ_b3", 64'(occ), 64'd1);
        bus.in_valid = 1'b0;
        cycle();
        check_val("bp_occ_empty", 64'(occ), 64'd0);

        // x0 suppression
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(mk(0, 32'hFF, 1, 4, 32'h44, 0));
        cycle();
        bus.in_valid = 1'b0;
        bus.fwd_addr = 0;
        #1;
        check_val("x0_we", 64'(bus.out_we), 64'd0);
        check_val("x0_data", 64'(bus.out_data[D-1:0]), 64'hFF);
        check_val("x0_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        check_val("x0_fwd_data", 64'(bus.fwd_data), 64'd0);
        flush_in = 1'b1;
        cycle();
        flush_in = 1'b0;
        check_val("flush_occ", 64'(occ), 64'd0);

        // Forward priority: E1 lane0 beats E0 lane1
        bus.in_valid = 1'b1;
        drive(mk(9, 32'h1, 1, 5, 32'hA, 1));
        cycle();
        drive(mk(5, 32'hB, 1, 6, 32'h2, 1));
        cycle();
        bus.in_valid = 1'b0;
        bus.fwd_addr = 5;
        #1;
        check_val("fp_hit", 64'(bus.fwd_hit), 64'd1);
        check_val("fp_data", 64'(bus.fwd_data), 64'hB);
        rdy_in = 1'b0;
        #1;
        check_val("fp_data_frozen", 64'(bus.fwd_data), 64'hB);

        // Freeze with occ=2, then asynchronous reset mid-cycle
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        drive(bk(7));
        repeat (5) begin
            cycle();
            check_val("frz_occ", 64'(occ), 64'd2);
            check_val("frz_out_valid", 64'(bus.out_valid), 64'd0);
        end
        #2;
        rst_in = 1'b0;
        #1;
        check_val("arst_occ", 64'(occ), 64'd0);
        check_val("arst_out_we", 64'(bus.out_we), 64'd0);
        check_val("arst_out_data", 64'(bus.out_data), 64'd0);
        check_val("arst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        q.delete();
        @(posedge clk_in);
        #1;
        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        bus.in_valid = 1'b0;

        // Flush wins over a same-cycle push
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(bk(1));
        cycle();
        check_val("fl_occ1", 64'(occ), 64'd1);
        flush_in = 1'b1;
        drive(bk(2));
        cycle();
        flush_in     = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_val("fl_occ0", 64'(occ), 64'd0);
        check_val("fl_out_valid", 64'(bus.out_valid), 64'd0);

        // Random traffic against the model
        repeat (600) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush_in      = ($urandom_range(0, 19) == 0);
            bus.in_valid  = $urandom_range(0, 1) != 0;
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.fwd_addr  = A'($urandom_range(0, 7));
            drive(mk(A'($urandom_range(0, 7)), D'($urandom), 1'($urandom_range(0, 1)),
                     A'($urandom_range(0, 7)), D'($urandom), 1'($urandom_range(0, 1))));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
